// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, FSM encoding, access-length encodings and
// small decode/load-extension helpers.
package mmio_uart_tx_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COUNT_W = 3;

    // Access lengths, shared with the datapath load/store interface
    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    // Register word index (address bits [3:2]) inside the window
    localparam logic [1:0] REG_TXDATA = 2'd0;   // offset 0x0
    localparam logic [1:0] REG_STATUS = 2'd1;   // offset 0x4
    localparam logic [1:0] REG_CTRL   = 2'd2;   // offset 0x8

    // STATUS bit positions
    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_ACTIVE    = 2;
    localparam int unsigned ST_COUNT_LSB = 3;
    localparam int unsigned ST_OVERFLOW  = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // Window hit: same 16-byte block as base and one of the three registers
    function automatic logic in_window(input logic [DATA_W-1:0] addr,
                                       input logic [DATA_W-1:0] base);
        return (addr[31:4] == base[31:4]) && (addr[3:2] != 2'b11);
    endfunction

    // Narrow a register word to the load size with sign/zero extension
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0]        len,
                                                      input logic              sgn);
        logic [DATA_W-1:0] r;
        r = '0;
        case (len)
            LEN_BYTE: r = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'b0, raw[7:0]};
            LEN_HALF: r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
            LEN_WORD: r = raw;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte FIFO for mmio_uart_tx.
// Ports:
//   SYS_clk, SYS_reset : clock, synchronous active-high reset
//   push, wdata        : enqueue request and byte
//   pop                : dequeue request (head is consumed on this edge)
//   head               : byte at the read pointer
//   count, full, empty : occupancy
// A push while full is accepted only if a pop happens on the same edge.
module uart_tx_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               SYS_clk,
    input  logic               SYS_reset,
    input  logic               push,
    input  logic [BYTE_W-1:0]  wdata,
    input  logic               pop,
    output logic [BYTE_W-1:0]  head,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned        PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEPTH);

    logic [BYTE_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == COUNT_MAX);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers and occupancy
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage; contents are don't-care while empty, so no reset
    always_ff @(posedge SYS_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory interface.
// Ports:
//   SYS_clk, SYS_reset       : clock, synchronous active-high reset
//   MEM_write_length/data/address : store from the datapath (TXDATA push,
//                              STATUS overflow clear, CTRL enable)
//   MEM_read_length/signed/address : load from the datapath
//   MEM_read_data, MEM_read_hit : combinational load response
//   UART_tx                  : serial line, idles high
//   UART_busy                : FSM active or FIFO holding bytes
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic [1:0]        MEM_write_length,
    input  logic [DATA_W-1:0] MEM_write_data,
    input  logic [DATA_W-1:0] MEM_write_address,
    input  logic [1:0]        MEM_read_length,
    input  logic              MEM_read_signed,
    input  logic [DATA_W-1:0] MEM_read_address,
    output logic [DATA_W-1:0] MEM_read_data,
    output logic              MEM_read_hit,
    output logic              UART_tx,
    output logic              UART_busy
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // Store decode
    logic       wr_hit;
    logic [1:0] wr_reg;
    logic       push;
    logic       ovf_clr;
    logic       ctrl_wr;

    assign wr_hit  = in_window(MEM_write_address, BASE_ADDRESS) && (MEM_write_length != LEN_NONE);
    assign wr_reg  = MEM_write_address[3:2];
    assign push    = wr_hit && (wr_reg == REG_TXDATA);
    assign ovf_clr = wr_hit && (wr_reg == REG_STATUS);
    assign ctrl_wr = wr_hit && (wr_reg == REG_CTRL);

    // FIFO
    logic [BYTE_W-1:0]  fifo_head;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .push      (push),
        .wdata     (MEM_write_data[7:0]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Control/status registers
    logic enable_q;
    logic overflow_q;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            enable_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= MEM_write_data[0];
            end
            // A full push is only lost when no pop frees a slot on this edge
            if (ovf_clr) begin
                overflow_q <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmit FSM
    tx_state_e         state_q,   state_d;
    logic [BAUD_W-1:0] baud_q,    baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q,   shift_d;
    logic              tx_q,      tx_d;
    logic              baud_last;
    logic              can_pop;

    assign baud_last = (baud_q == BAUD_LAST);
    assign can_pop   = enable_q && !fifo_empty;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so the registered
    // UART_tx changes on the same edge as the state
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (can_pop) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit: no idle gap
                    if (can_pop) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign UART_tx   = tx_q;
    // Derived only from registered state
    assign UART_busy = (state_q != S_IDLE) || !fifo_empty;

    // Load path: side-effect free, combinational from registered state
    logic [1:0]        rd_reg;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_raw;

    always_comb begin
        status_word                                 = '0;
        status_word[ST_FULL]                        = fifo_full;
        status_word[ST_EMPTY]                       = fifo_empty;
        status_word[ST_ACTIVE]                      = (state_q != S_IDLE);
        status_word[ST_COUNT_LSB +: COUNT_W]        = fifo_count;
        status_word[ST_OVERFLOW]                    = overflow_q;
    end

    assign rd_reg       = MEM_read_address[3:2];
    assign MEM_read_hit = in_window(MEM_read_address, BASE_ADDRESS);

    always_comb begin
        rd_raw = '0;
        case (rd_reg)
            REG_STATUS: rd_raw = status_word;
            REG_CTRL:   rd_raw = {31'b0, enable_q};
            default:    rd_raw = '0;
        endcase
    end

    assign MEM_read_data = MEM_read_hit ? load_extend(rd_raw, MEM_read_length, MEM_read_signed) : '0;

    // Byte lanes and address bits the register file does not look at
    logic unused_bits;
    assign unused_bits = ^{MEM_write_data[31:8], MEM_write_address[1:0], MEM_read_address[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: register loads are checked directly,
// serial frames are decoded by a monitor and compared against queued bytes.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int unsigned C    = 4;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  wlen, rlen, b_wlen, b_rlen;
    logic [31:0] wdata, waddr, raddr, b_wdata, b_waddr, b_raddr;
    logic        rsgn, b_rsgn;
    logic [31:0] rdata, b_rdata;
    logic        hit, tx, busy, b_hit, b_tx, b_busy;

    mmio_uart_tx #(.BASE_ADDRESS(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .SYS_clk(clk), .SYS_reset(rst),
        .MEM_write_length(wlen), .MEM_write_data(wdata), .MEM_write_address(waddr),
        .MEM_read_length(rlen), .MEM_read_signed(rsgn), .MEM_read_address(raddr),
        .MEM_read_data(rdata), .MEM_read_hit(hit), .UART_tx(tx), .UART_busy(busy)
    );

    mmio_uart_tx #(.BASE_ADDRESS(BASE), .CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut_b (
        .SYS_clk(clk), .SYS_reset(rst),
        .MEM_write_length(b_wlen), .MEM_write_data(b_wdata), .MEM_write_address(b_waddr),
        .MEM_read_length(b_rlen), .MEM_read_signed(b_rsgn), .MEM_read_address(b_raddr),
        .MEM_read_data(b_rdata), .MEM_read_hit(b_hit), .UART_tx(b_tx), .UART_busy(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;   // expected cycle of first start-bit sample, -1 = any
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One store, presented for exactly one rising edge
    task automatic store(input bit sel, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] data);
        if (sel) begin b_waddr = addr; b_wlen = len; b_wdata = data; end
        else     begin waddr   = addr; wlen   = len; wdata   = data; end
        @(posedge clk);
        #1;
        last_edge = cyc;
        wlen   = LEN_NONE;
        b_wlen = LEN_NONE;
    endtask

    task automatic load(input bit sel, input string name, input logic [31:0] addr,
                        input logic [1:0] len, input logic sgn,
                        input logic exp_hit, input logic [31:0] exp_data);
        if (sel) begin b_raddr = addr; b_rlen = len; b_rsgn = sgn; end
        else     begin raddr   = addr; rlen   = len; rsgn   = sgn; end
        @(negedge clk);
        check({name, "_hit"},  sel ? 32'(b_hit) : 32'(hit), 32'(exp_hit));
        check({name, "_data"}, sel ? b_rdata : rdata, exp_data);
        raddr = '0; rlen = LEN_WORD; rsgn = 1'b0;
        b_raddr = '0; b_rlen = LEN_WORD; b_rsgn = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Frame monitor: samples every cycle of a frame on the falling edge
    initial begin : monitor
        logic [9:0] s;
        bit         glitch;
        bit         aborted;
        int         st;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                st = cyc; s = '0; glitch = 0; aborted = 0;
                for (int k = 1; k < 10 * C; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1;
                        break;
                    end
                    if (k % C == 0) s[k / C] = tx;
                    else if (tx !== s[k / C]) glitch = 1;
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got 0x%02h expected no frame", s[8:1]);
                    end else begin
                        e = sb.pop_front();
                        check("frame_data",   32'(s[8:1]), 32'(e.data));
                        check("frame_stop",   32'(s[9]),   32'd1);
                        check("frame_stable", 32'(glitch), 32'd0);
                        if (e.start >= 0) check("frame_start_cycle", 32'(st), 32'(e.start));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int t0;
        rst = 1'b1;
        wlen = LEN_NONE; wdata = '0; waddr = '0;
        rlen = LEN_WORD; rsgn = 1'b0; raddr = '0;
        b_wlen = LEN_NONE; b_wdata = '0; b_waddr = '0;
        b_rlen = LEN_WORD; b_rsgn = 1'b0; b_raddr = '0;

        // 1. Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        load(0, "rst_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0002);
        load(0, "rst_ctrl",   A_CT, LEN_WORD, 1'b0, 1'b1, 32'h0000_0001);
        check("rst_tx",     32'(tx),     32'd1);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_b_tx",   32'(b_tx),   32'd1);
        check("rst_b_busy", 32'(b_busy), 32'd0);

        // 2. Single frame of 0x55
        store(0, A_TX, LEN_BYTE, 32'h0000_0055);
        t0 = last_edge;
        sb.push_back('{8'h55, t0 + 1});
        wait_until(t0 + 40);
        check("single_busy_last", 32'(busy), 32'd1);
        wait_until(t0 + 41);
        check("single_busy_drop", 32'(busy), 32'd0);

        // 3. Overflow, then four back-to-back frames
        store(0, A_CT, LEN_WORD, 32'h0);
        store(0, A_TX, LEN_BYTE, 32'h11);
        store(0, A_TX, LEN_BYTE, 32'h22);
        store(0, A_TX, LEN_BYTE, 32'h33);
        store(0, A_TX, LEN_BYTE, 32'h44);
        store(0, A_TX, LEN_BYTE, 32'h55);
        load(0, "ovf_lw",  A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0061);
        load(0, "ovf_lbu", A_ST, LEN_BYTE, 1'b0, 1'b1, 32'h0000_0061);
        load(0, "ovf_lb",  A_ST, LEN_BYTE, 1'b1, 1'b1, 32'h0000_0061);
        store(0, A_CT, LEN_WORD, 32'h1);
        t0 = last_edge;
        sb.push_back('{8'h11, t0 + 1});
        sb.push_back('{8'h22, t0 + 41});
        sb.push_back('{8'h33, t0 + 81});
        sb.push_back('{8'h44, t0 + 121});
        wait_idle("b2b_idle", 400);
        load(0, "b2b_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0042);
        store(0, A_ST, LEN_WORD, 32'h0);
        load(0, "ovf_clear", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0002);

        // 4. Decode, length-00 store, disable mid-frame
        load(0, "miss_c",   BASE + 32'hC, LEN_WORD, 1'b0, 1'b0, 32'h0);
        load(0, "miss_low", BASE - 32'h4, LEN_WORD, 1'b0, 1'b0, 32'h0);
        load(0, "lb_ctrl",  A_CT,         LEN_BYTE, 1'b1, 1'b1, 32'h0000_0001);
        load(0, "lw_txd",   A_TX,         LEN_WORD, 1'b0, 1'b1, 32'h0);
        store(0, BASE + 32'h3, LEN_WORD, 32'hDEAD_BE3C);
        t0 = last_edge;
        sb.push_back('{8'h3C, t0 + 1});
        store(0, BASE + 32'hC, LEN_WORD, 32'h0000_00AA);
        store(0, A_TX, LEN_NONE, 32'h0000_00BB);
        load(0, "dec_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0006);
        store(0, A_TX, LEN_BYTE, 32'h81);
        store(0, A_CT, LEN_WORD, 32'h0);
        load(0, "dis_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_000C);
        wait_until(t0 + 42);
        load(0, "dis_held", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0008);
        store(0, A_CT, LEN_WORD, 32'h1);
        sb.push_back('{8'h81, last_edge + 1});
        wait_idle("reen_idle", 200);

        // 5. Reset during data bit 3
        store(0, A_TX, LEN_BYTE, 32'hF0);
        t0 = last_edge;
        store(0, A_CT, LEN_WORD, 32'h0);
        wait_until(t0 + 18);
        check("bit3_level", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_tx", 32'(tx), 32'd1);
        load(0, "midrst_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0002);
        load(0, "midrst_ctrl",   A_CT, LEN_WORD, 1'b0, 1'b1, 32'h0000_0001);

        // 6. Push into a full FIFO on the edge of the first pop (16 clocks/bit)
        store(1, A_CT, LEN_WORD, 32'h0);
        store(1, A_TX, LEN_BYTE, 32'hA1);
        store(1, A_TX, LEN_BYTE, 32'hA2);
        store(1, A_TX, LEN_BYTE, 32'hA3);
        store(1, A_TX, LEN_BYTE, 32'hA4);
        load(1, "full_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0021);
        store(1, A_CT, LEN_WORD, 32'h1);
        store(1, A_TX, LEN_BYTE, 32'hA5);
        load(1, "pushpop_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0025);
        store(1, A_TX, LEN_BYTE, 32'hA6);
        load(1, "fullnopop_status", A_ST, LEN_WORD, 1'b0, 1'b1, 32'h0000_0065);

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
